// File: rtl/i2s_audio_scheduler.sv
// Stereo PCM FIFO feeding a Philips I2S serialiser with a valid/ready sample interface.
// Optional build macro AUDIO_I2S_MUTE_ON_UNDERRUN_EN: underrun sends silence instead of repeating the last frame.
module i2s_audio_scheduler #(
  parameter int AW = 2,
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [7:0]    bck_div,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [SW-1:0] s_left,
  input  logic [SW-1:0] s_right,
  output logic          hp_bck,
  output logic          hp_ws,
  output logic          hp_din,
  output logic [AW:0]   fifo_level,
  output logic [7:0]    underrun_cnt
);
  localparam int DEPTH = 1 << AW;
  localparam int FW    = 2 * SW;
  localparam int BW    = $clog2(FW);
  localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
  localparam logic [BW-1:0] SW_B   = BW'(SW);
  localparam logic [BW-1:0] LAST_B = BW'(FW - 1);

  logic [FW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic [7:0]    div_q, div_d, urun_q, urun_d;
  logic          bck_q, bck_d, ws_q, ws_d, din_q, din_d, run_q, run_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [FW-1:0] sr_q, sr_d, last_q, last_d;
  logic          push, pop, tc, bit_ev, wrap;

  assign s_ready      = (lvl_q != FULL);
  assign push         = s_valid && s_ready;
  // >= rather than == so a shrinking bck_div still ends the half-period next clk
  assign tc           = (div_q >= bck_div);
  assign bit_ev       = enable && tc && bck_q;
  // run_q low means no frame in flight yet: the first bit event is a frame boundary
  assign wrap         = bit_ev && (!run_q || bit_q == LAST_B);
  assign pop          = wrap && (lvl_q != '0);

  assign hp_bck       = bck_q;
  assign hp_ws        = ws_q;
  assign hp_din       = din_q;
  assign fifo_level   = lvl_q;
  assign underrun_cnt = urun_q;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    lvl_d  = lvl_q;
    div_d  = div_q;
    bck_d  = bck_q;
    ws_d   = ws_q;
    din_d  = din_q;
    run_d  = run_q;
    bit_d  = bit_q;
    sr_d   = sr_q;
    last_d = last_q;
    urun_d = urun_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
    if (!enable) begin
      div_d = '0;
      bck_d = 1'b0;
      ws_d  = 1'b0;
      din_d = 1'b0;
      run_d = 1'b0;
      bit_d = '0;
      sr_d  = '0;
    end else begin
      div_d = tc ? 8'd0 : 8'(div_q + 8'd1);
      if (tc) bck_d = !bck_q;
      if (bit_ev) begin
        run_d = 1'b1;
        // after 2*SW-1 shifts the MSB holds R[0] of the outgoing frame
        din_d = sr_q[FW-1];
        if (wrap) begin
          bit_d = '0;
          ws_d  = 1'b0;
          if (lvl_q != '0) begin
            sr_d   = mem_q[rd_q];
            last_d = mem_q[rd_q];
          end else begin
`ifdef AUDIO_I2S_MUTE_ON_UNDERRUN_EN
            sr_d   = '0;
            last_d = '0;
`else
            sr_d   = last_q;
`endif
            if (urun_q != 8'hFF) urun_d = urun_q + 8'd1;
          end
        end else begin
          bit_d = bit_q + 1'b1;
          ws_d  = (bit_d >= SW_B);
          sr_d  = sr_q << 1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      div_q  <= '0;
      bck_q  <= 1'b0;
      ws_q   <= 1'b0;
      din_q  <= 1'b0;
      run_q  <= 1'b0;
      bit_q  <= '0;
      sr_q   <= '0;
      last_q <= '0;
      urun_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      div_q  <= div_d;
      bck_q  <= bck_d;
      ws_q   <= ws_d;
      din_q  <= din_d;
      run_q  <= run_d;
      bit_q  <= bit_d;
      sr_q   <= sr_d;
      last_q <= last_d;
      urun_q <= urun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {s_left, s_right};
  end
endmodule

// File: tb/tb_i2s_audio_scheduler.sv
// Scoreboard bench: stimulus queues expected {L,R} frames, a monitor decodes the I2S stream and compares.
module tb_i2s_audio_scheduler;
  logic        clk = 0, reset = 1, enable = 0, s_valid = 0;
  logic [7:0]  bck_div = 8'd3;
  logic [15:0] s_left = '0, s_right = '0;
  logic        s_ready, hp_bck, hp_ws, hp_din;
  logic [2:0]  fifo_level;
  logic [7:0]  underrun_cnt;
  int checks = 0, failures = 0;
  logic [31:0] exp_q [$];

  i2s_audio_scheduler #(.AW(2), .SW(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bck_div(bck_div),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .hp_bck(hp_bck), .hp_ws(hp_ws), .hp_din(hp_din),
    .fifo_level(fifo_level), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait expired, got no event expected event", name);
  endtask

  task automatic wait_level(input logic [2:0] v);
    int i;
    for (i = 0; i < 3000 && fifo_level !== v; i++) @(negedge clk);
    if (fifo_level !== v) timeout("wait_level");
  endtask

  task automatic wait_urun(input logic [7:0] v);
    int i;
    for (i = 0; i < 3000 && underrun_cnt !== v; i++) @(negedge clk);
    if (underrun_cnt !== v) timeout("wait_underrun");
  endtask

  task automatic wait_qempty();
    int i;
    for (i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) timeout("wait_frames_drained");
  endtask

  task automatic wait_ws_rise();
    logic p;
    int i;
    bit hit;
    p = hp_ws; hit = 0;
    for (i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      hit = hp_ws && !p;
      p = hp_ws;
    end
    if (!hit) timeout("wait_ws_rise");
  endtask

  task automatic wait_bck_rise();
    logic p;
    int i;
    bit hit;
    p = hp_bck; hit = 0;
    for (i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = hp_bck && !p;
      p = hp_bck;
    end
    if (!hit) timeout("wait_bck_rise");
  endtask

  task automatic bit_events(input int n);
    logic p;
    int i, k;
    p = hp_bck; k = 0;
    for (i = 0; i < 100 * n && k < n; i++) begin
      @(negedge clk);
      if (p && !hp_bck) k++;
      p = hp_bck;
    end
    if (k < n) timeout("bit_events");
  endtask

  // Monitor: samples on rising hp_bck like the codec; first rise after enable precedes bit 0
  initial begin
    logic pb;
    logic skip, have;
    int mcnt;
    logic [30:0] acc;
    logic [31:0] wacc, exp;
    pb = 0; skip = 1; have = 0; mcnt = 0; acc = '0; wacc = '0;
    forever begin
      @(negedge clk);
      if (reset || !enable) begin
        mcnt = 0; skip = 1; have = 0; pb = 0;
      end else begin
        if (hp_bck && !pb) begin
          if (skip) skip = 0;
          else begin
            if (mcnt == 0) begin
              if (have) begin
                if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL frame_data: got %h expected no frame", {acc, hp_din});
                end else begin
                  exp = exp_q.pop_front();
                  chk("frame_data", {acc, hp_din}, exp);
                end
                chk("ws_pattern", wacc, 32'h0000FFFF);
              end
              have = 1; acc = '0; wacc = {31'b0, hp_ws};
            end else begin
              acc  = {acc[29:0], hp_din};
              wacc = {wacc[30:0], hp_ws};
            end
            mcnt = (mcnt == 31) ? 0 : mcnt + 1;
          end
        end
        pb = hp_bck;
      end
    end
  end

  logic [31:0] fill_tab [5] = '{32'hA5C3_0F01, 32'h8001_7FFE, 32'hFFFF_0000,
                                32'h0123_4567, 32'h7777_8888};

  initial begin
    int n_acc, t0, t1, bad;
    logic rdy5;
    logic [31:0] fr;
    // reset and idle
    #1;
    chk("reset_outputs", {29'b0, hp_bck, hp_ws, hp_din}, 32'd0);
    chk("reset_ready", {31'b0, s_ready}, 32'd1);
    chk("reset_level", {29'b0, fifo_level}, 32'd0);
    chk("reset_underrun", {24'b0, underrun_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (hp_bck || hp_ws || hp_din || !s_ready || fifo_level != 0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // fill with stream stopped
    n_acc = 0; rdy5 = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fr = fill_tab[i];
      s_valid = 1; s_left = fr[31:16]; s_right = fr[15:0];
      if (s_ready) begin n_acc++; exp_q.push_back(fr); end
      if (i == 4) rdy5 = s_ready;
    end
    @(negedge clk);
    s_valid = 0;
    chk("fill_accepted", n_acc, 4);
    chk("fill_ready_5th", {31'b0, rdy5}, 32'd0);
    chk("fill_level", {29'b0, fifo_level}, 32'd4);

    // stream at bck_div=3
    enable = 1;
    wait_bck_rise();
    t0 = 0;
    begin
      logic p;
      p = hp_bck;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        t0++;
        if (hp_bck && !p) break;
        p = hp_bck;
      end
    end
    chk("bck_period", t0, 8);

    // push exactly on the boundary clk of frame 3 while level is 2
    wait_level(3'd2);
    wait_ws_rise();
    bit_events(15);
    wait_bck_rise();
    repeat (3) @(posedge clk);
    #1;
    chk("level_before_pushpop", {29'b0, fifo_level}, 32'd2);
    s_valid = 1; s_left = 16'h9999; s_right = 16'hAAAA;
    exp_q.push_back(32'h9999_AAAA);
    @(posedge clk);
    #1;
    s_valid = 0;
    chk("level_pushpop", {29'b0, fifo_level}, 32'd2);

    // first underrun frame, then async reset at bit 9
    wait_urun(8'd1);
    bit_events(9);
    t1 = exp_q.size();
    chk("frames_drained", t1, 0);
    chk("underrun_one", {24'b0, underrun_cnt}, 32'd1);
    reset = 1;
    #1;
    chk("async_reset_outputs", {29'b0, hp_bck, hp_ws, hp_din}, 32'd0);
    chk("async_reset_level", {29'b0, fifo_level, s_ready}, 32'd1);
    chk("async_reset_underrun", {24'b0, underrun_cnt}, 32'd0);
    enable = 0;
    repeat (3) @(negedge clk);
    reset = 0;

    // one frame then starvation
    @(negedge clk);
    s_valid = 1; s_left = 16'h1234; s_right = 16'h5678;
    @(negedge clk);
    s_valid = 0;
    exp_q.push_back(32'h1234_5678);
`ifdef AUDIO_I2S_MUTE_ON_UNDERRUN_EN
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
`else
    exp_q.push_back(32'h1234_5678); exp_q.push_back(32'h1234_5678);
`endif
    enable = 1;
    wait_urun(8'd2);
    bit_events(4);
    chk("underrun_two", {24'b0, underrun_cnt}, 32'd2);
    chk("underrun_level", {29'b0, fifo_level}, 32'd0);
    wait_qempty();
    chk("underrun_three", {24'b0, underrun_cnt}, 32'd3);

    // disable mid-frame: outputs idle, pushes still land
    @(negedge clk);
    enable = 0;
    @(negedge clk);
    s_valid = 1; s_left = 16'h4242; s_right = 16'h2424;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      s_valid = 0;
      if (hp_bck || hp_ws || hp_din) bad++;
    end
    chk("disable_quiet", bad, 0);
    chk("disable_push_level", {29'b0, fifo_level}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
